// File: rtl/fifo_feeder_pkg.sv
// Shared types and defaults for the FIFO-to-UART feeder.
// Reused by the RTL and the bench.
package fifo_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_POP  = 2'b01,
    ST_SEND = 2'b10,
    ST_WAIT = 2'b11
  } feeder_state_e;

  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_CNT_WIDTH   = 16;
  localparam int DEF_TIMEOUT_CYC = 255;

  function automatic int cnt_bits(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/feeder_timeout_cnt.sv
// Handshake watchdog for the feeder SEND state.
// Clear/enable/expire; only built with FEEDER_TIMEOUT_EN.
module feeder_timeout_cnt
  import fifo_feeder_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int W = cnt_bits(TIMEOUT_CYC);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign expire = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expire) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_uart_feeder.sv
// Pops async-FIFO words and hands them to UART TX (r_clk domain).
// Optional handshake timeout: FEEDER_TIMEOUT_EN.
module fifo_uart_feeder
  import fifo_feeder_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                  r_clk,
  input  logic                  r_rst_n,
  input  logic                  r_empty,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_inc,
  input  logic                  tx_busy,
  output logic                  tx_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic [CNT_WIDTH-1:0]  tx_count,
  output logic                  tx_timeout
);

  feeder_state_e         state_q, state_d;
  logic                  r_inc_q, r_inc_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [CNT_WIDTH-1:0]  tx_count_q, tx_count_d;

`ifdef FEEDER_TIMEOUT_EN
  logic tx_timeout_q, tx_timeout_d;
  logic to_expire;

  feeder_timeout_cnt #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_to_cnt (
    .clk   (r_clk),
    .rst_n (r_rst_n),
    .clr   (state_q != ST_SEND),
    .en    (state_q == ST_SEND),
    .expire(to_expire)
  );

  assign tx_timeout = tx_timeout_q;
`else
  assign tx_timeout = 1'b0;
`endif

  assign r_inc    = r_inc_q;
  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign tx_count = tx_count_q;

  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_count_d = tx_count_q;
`ifdef FEEDER_TIMEOUT_EN
    tx_timeout_d = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (!r_empty) state_d = ST_POP;
      end
      ST_POP: begin
        tx_data_d = r_data;
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        // busy already high on entry is taken as the accept
        if (tx_busy) begin
          state_d = ST_WAIT;
`ifdef FEEDER_TIMEOUT_EN
        end else if (to_expire) begin
          state_d      = ST_IDLE;
          tx_timeout_d = 1'b1;
`endif
        end
      end
      ST_WAIT: begin
        if (!tx_busy) begin
          tx_count_d = tx_count_q + CNT_WIDTH'(1);
          state_d    = r_empty ? ST_IDLE : ST_POP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    r_inc_d    = (state_d == ST_POP);
    tx_valid_d = (state_d == ST_SEND);
  end

  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      state_q    <= ST_IDLE;
      r_inc_q    <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      tx_count_q <= '0;
    end else begin
      state_q    <= state_d;
      r_inc_q    <= r_inc_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      tx_count_q <= tx_count_d;
    end
  end

`ifdef FEEDER_TIMEOUT_EN
  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      tx_timeout_q <= 1'b0;
    end else begin
      tx_timeout_q <= tx_timeout_d;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_uart_feeder.sv
// Directed bench for fifo_uart_feeder with FIFO and UART responders.
// Timeout case runs only when FEEDER_TIMEOUT_EN is defined.
module tb_fifo_uart_feeder;
  import fifo_feeder_pkg::*;

  localparam int DW = DEF_DATA_WIDTH;
  localparam int CW = DEF_CNT_WIDTH;
  localparam int BUSY_LEN = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          r_empty = 1'b1;
  logic [DW-1:0] r_data = '0;
  logic          r_inc;
  logic          tx_busy = 1'b0;
  logic          tx_valid;
  logic [DW-1:0] tx_data;
  logic [CW-1:0] tx_count;
  logic          tx_timeout;

  fifo_uart_feeder #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW),
    .TIMEOUT_CYC(16)
  ) dut (
    .r_clk     (clk),
    .r_rst_n   (rst_n),
    .r_empty   (r_empty),
    .r_data    (r_data),
    .r_inc     (r_inc),
    .tx_busy   (tx_busy),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_count  (tx_count),
    .tx_timeout(tx_timeout)
  );

  always #5 clk = ~clk;

  int n_run = 0;
  int n_fail = 0;

  logic [DW-1:0] fq[$];
  logic [DW-1:0] sent[$];
  int gaps[$];
  int busy_left = 0;
  bit uart_on = 1'b1;
  int cyc_n = 0;
  int last_pop = -1;
  int n_pop = 0;
  int n_bad = 0;
  int n_to = 0;
  int to_cyc = -1;

  logic          s_inc, s_valid, s_to;
  logic [DW-1:0] s_data;
  logic [CW-1:0] s_cnt;

  task automatic check_eq(input string tag,
                          input logic [31:0] got,
                          input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_fifo();
    r_empty = (fq.size() == 0);
    r_data  = r_empty ? '0 : fq[0];
  endtask

  task automatic push(input logic [DW-1:0] w);
    fq.push_back(w);
    drive_fifo();
  endtask

  task automatic cyc();
    logic pop, acc;
    @(negedge clk);
    s_inc   = r_inc;
    s_valid = tx_valid;
    s_data  = tx_data;
    s_cnt   = tx_count;
    s_to    = tx_timeout;
    pop = r_inc;
    acc = uart_on && tx_valid && !tx_busy;
    if (r_inc && r_empty) n_bad++;
    if (tx_timeout) begin
      n_to++;
      if (to_cyc < 0) to_cyc = cyc_n;
    end
    if (pop) begin
      n_pop++;
      if (last_pop >= 0) gaps.push_back(cyc_n - last_pop);
      last_pop = cyc_n;
    end
    if (acc) sent.push_back(tx_data);
    @(posedge clk);
    #1;
    cyc_n++;
    if (pop && fq.size() > 0) void'(fq.pop_front());
    if (acc) busy_left = BUSY_LEN;
    if (busy_left > 0) begin
      tx_busy = 1'b1;
      busy_left--;
    end else begin
      tx_busy = 1'b0;
    end
    drive_fifo();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic clear_models();
    fq.delete();
    sent.delete();
    gaps.delete();
    busy_left = 0;
    tx_busy = 1'b0;
    last_pop = -1;
    drive_fifo();
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    clear_models();
    run(2);
    rst_n = 1'b1;
    run(2);
  endtask

  initial begin
    int p0, s0, t0;

    // 1: reset held with a word waiting
    push(8'h3C);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check_eq("rst_inc", 32'(s_inc), 32'd0);
      check_eq("rst_valid", 32'(s_valid), 32'd0);
      check_eq("rst_cnt", 32'(s_cnt), 32'd0);
    end
    clear_models();
    run(1);
    rst_n = 1'b1;
    run(2);

    // 2: single word, cycle-exact latency
    push(8'hA5);
    cyc();
    check_eq("t2_inc_c0", 32'(s_inc), 32'd0);
    cyc();
    check_eq("t2_inc_c1", 32'(s_inc), 32'd1);
    check_eq("t2_valid_c1", 32'(s_valid), 32'd0);
    cyc();
    check_eq("t2_inc_c2", 32'(s_inc), 32'd0);
    check_eq("t2_valid_c2", 32'(s_valid), 32'd1);
    check_eq("t2_data_c2", 32'(s_data), 32'hA5);
    run(10);
    check_eq("t2_cnt_busy", 32'(s_cnt), 32'd0);
    run(5);
    check_eq("t2_cnt_done", 32'(s_cnt), 32'd1);
    check_eq("t2_sent_n", 32'(sent.size()), 32'd1);

    // 3: burst of four, back-to-back
    reset_dut();
    p0 = n_pop;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    push(8'h44);
    run(70);
    check_eq("t3_pops", 32'(n_pop - p0), 32'd4);
    check_eq("t3_sent_n", 32'(sent.size()), 32'd4);
    for (int i = 0; i < 4 && i < sent.size(); i++)
      check_eq($sformatf("t3_data%0d", i), 32'(sent[i]), 32'(8'h11 * (i + 1)));
    check_eq("t3_gaps_n", 32'(gaps.size()), 32'd3);
    for (int i = 0; i < gaps.size(); i++)
      check_eq($sformatf("t3_gap%0d", i), 32'(gaps[i]), 32'd13);
    check_eq("t3_cnt", 32'(s_cnt), 32'd4);

    // 4: FIFO drains after word 2, then resumes
    p0 = n_pop;
    sent.delete();
    push(8'h5B);
    push(8'h6C);
    run(40);
    check_eq("t4_pops", 32'(n_pop - p0), 32'd2);
    check_eq("t4_cnt", 32'(s_cnt), 32'd6);
    cyc();
    check_eq("t4_idle_inc", 32'(s_inc), 32'd0);
    push(8'h7D);
    cyc();
    check_eq("t4_res_c0", 32'(s_inc), 32'd0);
    cyc();
    check_eq("t4_res_c1", 32'(s_inc), 32'd1);
    run(16);
    check_eq("t4_pops_all", 32'(n_pop - p0), 32'd3);
    check_eq("t4_last", 32'(sent.size() == 3 ? sent[2] : 8'h00), 32'h7D);
    check_eq("t4_cnt_all", 32'(s_cnt), 32'd7);

    // 5: reset while waiting on busy
    push(8'h5A);
    run(6);
    check_eq("t5_in_wait", 32'(tx_busy & ~tx_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t5_rst_inc", 32'(r_inc), 32'd0);
    check_eq("t5_rst_valid", 32'(tx_valid), 32'd0);
    check_eq("t5_rst_data", 32'(tx_data), 32'd0);
    check_eq("t5_rst_cnt", 32'(tx_count), 32'd0);
    clear_models();
    run(2);
    rst_n = 1'b1;
    p0 = n_pop;
    s0 = sent.size();
    run(30);
    check_eq("t5_no_pop", 32'(n_pop - p0), 32'd0);
    check_eq("t5_no_send", 32'(sent.size() - s0), 32'd0);
    check_eq("t5_cnt", 32'(s_cnt), 32'd0);

`ifdef FEEDER_TIMEOUT_EN
    // 6: UART never answers, word dropped after 16 SEND cycles
    uart_on = 1'b0;
    to_cyc = -1;
    t0 = cyc_n;
    push(8'h77);
    run(24);
    check_eq("t6_to_cyc", 32'(to_cyc - t0), 32'd18);
    check_eq("t6_to_n", 32'(n_to), 32'd1);
    check_eq("t6_cnt", 32'(s_cnt), 32'd0);
    uart_on = 1'b1;
    s0 = sent.size();
    push(8'h88);
    run(20);
    check_eq("t6_next_n", 32'(sent.size() - s0), 32'd1);
    check_eq("t6_next", 32'(sent.size() > s0 ? sent[s0] : 8'h00), 32'h88);
    check_eq("t6_next_cnt", 32'(s_cnt), 32'd1);
`else
    t0 = 0;
    check_eq("no_timeout", 32'(n_to + t0), 32'd0);
`endif

    check_eq("no_empty_pop", 32'(n_bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
